dcache_flush_sequencer: RTL and testbench

Walks every D-cache set and way on a flush request, writes back each dirty line to memory, and cleans or invalidates it in the tag/data arrays. Sits beside the D-cache controller: requests one array port through the existing port arbiter, issues line writebacks on a dedicated memory request channel, and reports start/completion to the controller. It drives the flush-in-progress signal that blocks LSU array requests.

---
 rtl/dcache_flush_sequencer.sv | 167 ++++++++++++++++
 tb/tb_dcache_flush_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_flush_sequencer.sv
// D-cache flush sequencer: walks every set/way, writes back dirty lines and cleans them.
// Define DCACHE_FLUSH_INVALIDATE_EN to invalidate every valid line instead of only cleaning dirty ones.
module dcache_flush_sequencer #(
  parameter int unsigned INDEX_NUM = 64,
  parameter int unsigned WAY_NUM   = 2,
  parameter int unsigned TAG_W     = 20,
  parameter int unsigned OFFSET_W  = 4,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned MAX_WB    = 4,
  localparam int unsigned IDX_W    = $clog2(INDEX_NUM),
  localparam int unsigned WAY_W    = $clog2(WAY_NUM),
  localparam int unsigned ADDR_W   = TAG_W + IDX_W + OFFSET_W,
  localparam int unsigned CNT_W    = $clog2(MAX_WB + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flushReq,
  output logic              flushReqAck,
  output logic              flushing,
  output logic              flushComplete,
  input  logic              mshrIdle,
  output logic              arrayReq,
  input  logic              arrayGrt,
  output logic              arrayWE,
  output logic [IDX_W-1:0]  arrayIndex,
  output logic [WAY_W-1:0]  arrayWay,
  output logic              arrayValidOut,
  input  logic              tagValidIn,
  input  logic              dirtyIn,
  input  logic [TAG_W-1:0]  tagIn,
  input  logic [LINE_W-1:0] lineIn,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  output logic [LINE_W-1:0] memData,
  input  logic              memAck,
  input  logic              memWriteDone
);

`ifdef DCACHE_FLUSH_INVALIDATE_EN
  localparam logic UPDATE_CLEAN = 1'b1;
  localparam logic VALID_AFTER  = 1'b0;
`else
  localparam logic UPDATE_CLEAN = 1'b0;
  localparam logic VALID_AFTER  = 1'b1;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_MSHR, S_READ, S_CHECK, S_WB, S_UPDATE, S_DRAIN, S_DONE
  } state_t;

  state_t              r_state, w_next;
  logic                r_ack;
  logic [IDX_W-1:0]    r_index;
  logic [WAY_W-1:0]    r_way;
  logic [TAG_W-1:0]    r_tag;
  logic [LINE_W-1:0]   r_line;
  logic [CNT_W-1:0]    r_outstanding;
  logic                w_accept, w_advance, w_capture, w_last, w_inc;

  assign w_last        = (r_index == '1) && (r_way == '1);
  assign w_inc         = memReq && memAck;
  assign flushReqAck   = r_ack;
  assign arrayIndex    = r_index;
  assign arrayWay      = r_way;
  assign memAddr       = {r_tag, r_index, {OFFSET_W{1'b0}}};
  assign memData       = r_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_advance     = 1'b0;
    w_capture     = 1'b0;
    flushing      = 1'b0;
    flushComplete = 1'b0;
    arrayReq      = 1'b0;
    arrayWE       = 1'b0;
    arrayValidOut = 1'b0;
    memReq        = 1'b0;
    case (r_state)
      S_IDLE: if (flushReq) begin
        w_accept = 1'b1;
        w_next   = S_WAIT_MSHR;
      end
      S_WAIT_MSHR: begin
        flushing = 1'b1;
        if (mshrIdle) w_next = S_READ;
      end
      S_READ: begin
        flushing = 1'b1;
        arrayReq = 1'b1;
        if (arrayGrt) w_next = S_CHECK;
      end
      S_CHECK: begin
        flushing  = 1'b1;
        w_capture = 1'b1;
        if (tagValidIn && dirtyIn)           w_next = S_WB;
        else if (tagValidIn && UPDATE_CLEAN) w_next = S_UPDATE;
        else                                 w_advance = 1'b1;
      end
      S_WB: begin
        flushing = 1'b1;
        // Throttle only the request; address/data are already held in registers.
        memReq   = (r_outstanding < CNT_W'(MAX_WB));
        if (memReq && memAck) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        flushing      = 1'b1;
        arrayReq      = 1'b1;
        arrayWE       = 1'b1;
        arrayValidOut = VALID_AFTER;
        if (arrayGrt) w_advance = 1'b1;
      end
      S_DRAIN: begin
        flushing = 1'b1;
        if (r_outstanding == '0) w_next = S_DONE;
      end
      S_DONE: begin
        flushComplete = 1'b1;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_advance) w_next = w_last ? S_DRAIN : S_READ;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack   <= 1'b0;
      r_index <= '0;
      r_way   <= '0;
      r_tag   <= '0;
      r_line  <= '0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_index <= '0;
        r_way   <= '0;
      end else if (w_advance) begin
        r_way <= r_way + 1'b1;
        if (r_way == '1) r_index <= r_index + 1'b1;
      end
      if (w_capture) begin
        r_tag  <= tagIn;
        r_line <= lineIn;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outstanding <= '0;
    end else if (w_inc && !memWriteDone) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_inc && memWriteDone && r_outstanding != '0) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

  a_no_done_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(memWriteDone && !w_inc && r_outstanding == '0));

endmodule

// File: tb/tb_dcache_flush_sequencer.sv
// Directed bench for dcache_flush_sequencer: 4 sets x 2 ways, MAX_WB=2, array/memory responder model.
module tb_dcache_flush_sequencer;

`ifdef DCACHE_FLUSH_INVALIDATE_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flushReq = 1'b0, mshrIdle = 1'b1;
  logic         flushReqAck, flushing, flushComplete;
  logic         arrayReq, arrayGrt, arrayWE, arrayValidOut;
  logic [1:0]   arrayIndex;
  logic         arrayWay;
  logic         tagValidIn, dirtyIn;
  logic [19:0]  tagIn;
  logic [127:0] lineIn;
  logic         memReq, memAck, memWriteDone;
  logic [25:0]  memAddr;
  logic [127:0] memData;

  dcache_flush_sequencer #(
    .INDEX_NUM(4), .WAY_NUM(2), .TAG_W(20), .OFFSET_W(4), .LINE_W(128), .MAX_WB(2)
  ) dut (
    .clk(clk), .rst(rst), .flushReq(flushReq), .flushReqAck(flushReqAck),
    .flushing(flushing), .flushComplete(flushComplete), .mshrIdle(mshrIdle),
    .arrayReq(arrayReq), .arrayGrt(arrayGrt), .arrayWE(arrayWE),
    .arrayIndex(arrayIndex), .arrayWay(arrayWay), .arrayValidOut(arrayValidOut),
    .tagValidIn(tagValidIn), .dirtyIn(dirtyIn), .tagIn(tagIn), .lineIn(lineIn),
    .memReq(memReq), .memAddr(memAddr), .memData(memData), .memAck(memAck),
    .memWriteDone(memWriteDone)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Array contents, flattened as {index, way}
  logic         m_valid [8];
  logic         m_dirty [8];
  logic [19:0]  m_tag   [8];
  logic [127:0] m_line  [8];
  logic [2:0]   rd_log [$];
  logic [3:0]   wr_log [$];
  logic [25:0]  wb_log [$];

  int n_cmp = 0, n_bad = 0;
  int grt_hold = 0, ack_hold = 0, done_req = 0, pend = 0;
  bit auto_done = 1'b1;
  int n_ack = 0, n_complete = 0, c_cyc = 0, memreq_cycles = 0;
  int arr_unstable = 0, mem_unstable = 0, pulse_err = 0;
  logic [25:0]  wb_addr_first;
  logic [127:0] wb_data_first;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] outs();
    return {flushReqAck, flushing, flushComplete, arrayReq, arrayWE, arrayIndex, arrayWay,
            arrayValidOut, memReq, memAddr, memData};
  endfunction

  // Responder: drives all array/memory inputs at the falling edge and logs traffic.
  initial begin : responder
    bit rd_pending = 0, a_wait = 0, m_wait = 0, prev_cmp = 0, prev_ack = 0;
    logic [2:0]   rd_i = '0;
    logic [3:0]   a_prev = '0;
    logic [25:0]  m_addr_prev = '0;
    logic [127:0] m_data_prev = '0;
    arrayGrt = 0; tagValidIn = 0; dirtyIn = 0; tagIn = '0; lineIn = '0;
    memAck = 0; memWriteDone = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rd_pending = 0; a_wait = 0; m_wait = 0; prev_cmp = 0; prev_ack = 0;
        pend = 0; done_req = 0; grt_hold = 0; ack_hold = 0;
        arrayGrt = 0; tagValidIn = 0; dirtyIn = 0; memAck = 0; memWriteDone = 0;
      end else begin
        if (rd_pending) begin
          tagValidIn = m_valid[rd_i]; dirtyIn = m_dirty[rd_i];
          tagIn = m_tag[rd_i]; lineIn = m_line[rd_i];
        end else begin
          tagValidIn = 0; dirtyIn = 0; tagIn = '0; lineIn = '0;
        end
        rd_pending = 0;
        if (a_wait && (!arrayReq || {arrayIndex, arrayWay, arrayWE} != a_prev)) arr_unstable++;
        arrayGrt = 0;
        if (arrayReq) begin
          if (grt_hold > 0) grt_hold--;
          else begin
            arrayGrt = 1;
            if (arrayWE) begin
              m_valid[{arrayIndex, arrayWay}] = arrayValidOut;
              m_dirty[{arrayIndex, arrayWay}] = 1'b0;
              wr_log.push_back({arrayIndex, arrayWay, arrayValidOut});
            end else begin
              rd_pending = 1; rd_i = {arrayIndex, arrayWay};
              rd_log.push_back(rd_i);
            end
          end
        end
        a_wait = arrayReq && !arrayGrt;
        a_prev = {arrayIndex, arrayWay, arrayWE};

        memWriteDone = 0;
        if (pend > 0 && (auto_done || done_req > 0)) begin
          memWriteDone = 1; pend--;
          if (!auto_done) done_req--;
        end
        if (m_wait && (!memReq || memAddr != m_addr_prev || memData != m_data_prev)) mem_unstable++;
        memAck = 0;
        if (memReq) begin
          memreq_cycles++;
          if (!m_wait) begin wb_addr_first = memAddr; wb_data_first = memData; end
          if (ack_hold > 0) ack_hold--;
          else begin memAck = 1; pend++; n_ack++; wb_log.push_back(memAddr); end
        end
        m_wait = memReq && !memAck;
        m_addr_prev = memAddr; m_data_prev = memData;

        if (flushComplete) begin n_complete++; c_cyc = cyc; end
        if ((flushComplete && prev_cmp) || (flushReqAck && prev_ack)) pulse_err++;
        prev_cmp = flushComplete; prev_ack = flushReqAck;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0;
      m_tag[i] = 20'($urandom); m_line[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    rd_log.delete(); wr_log.delete(); wb_log.delete();
    n_ack = 0; memreq_cycles = 0;
  endtask

  task automatic start_flush(output int t_ack);
    flushReq = 1;
    tick();
    check("ack_pulse", flushReqAck, 1);
    flushReq = 0;
    t_ack = cyc;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int start = n_complete;
    for (int i = 0; i < max_cyc && n_complete == start; i++) tick();
    check(tag, n_complete - start, 1);
  endtask

  initial begin
    int t_ack, n0;
    logic [127:0] line2;
    clear_model();
    repeat (3) tick();
    check("reset_outputs", outs(), '0);
    rst = 1;
    tick();

    // All invalid: 8 ordered reads, no writeback, complete 18 cycles after ack
    start_flush(t_ack);
    wait_done("t1_done", 60);
    check("t1_latency", c_cyc - t_ack, 18);
    check("t1_nreads", rd_log.size(), 8);
    for (int i = 0; i < 8 && i < rd_log.size(); i++) check("t1_read_order", rd_log[i], i);
    check("t1_no_memreq", memreq_cycles, 0);
    tick();
    check("t1_idle_after", {flushing, flushComplete}, 2'b00);

    // Dirty (2,1) tag 0x1A3 plus a clean (0,0)
    clear_model();
    line2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    m_valid[5] = 1; m_dirty[5] = 1; m_tag[5] = 20'h1A3; m_line[5] = line2;
    m_valid[0] = 1; m_dirty[0] = 0;
    start_flush(t_ack);
    wait_done("t2_done", 80);
    check("t2_memaddr", wb_addr_first, 26'h68E0);
    check("t2_memdata", wb_data_first, line2);
    check("t2_latency", c_cyc - t_ack, INV ? 21 : 20);
    check("t2_nwrites", wr_log.size(), INV ? 2 : 1);
    if (wr_log.size() > 0) check("t2_write_entry", wr_log[wr_log.size()-1], INV ? 4'b1010 : 4'b1011);
    check("t2_line_state", {m_valid[5], m_dirty[5]}, {!INV, 1'b0});

    // memAck withheld 5 cycles
    clear_model();
    m_valid[2] = 1; m_dirty[2] = 1; m_tag[2] = 20'h12345;
    ack_hold = 5;
    start_flush(t_ack);
    wait_done("t3_done", 80);
    check("t3_memreq_cycles", memreq_cycles, 6);
    check("t3_mem_stable", mem_unstable, 0);
    check("t3_nwrites", wr_log.size(), 1);
    if (wb_log.size() > 0) check("t3_memaddr", wb_log[0], 26'h48D150);

    // MAX_WB=2 throttle with three dirty lines
    clear_model();
    for (int i = 0; i < 3; i++) begin m_valid[i] = 1; m_dirty[i] = 1; end
    auto_done = 0;
    n0 = n_complete;
    start_flush(t_ack);
    for (int i = 0; i < 60 && n_ack < 2; i++) tick();
    repeat (6) tick();
    check("t4_throttled", {memReq, arrayReq, flushing, 6'(n_ack)}, {3'b001, 6'd2});
    done_req = 1;
    for (int i = 0; i < 10 && n_ack < 3; i++) tick();
    check("t4_third_issued", n_ack, 3);
    repeat (30) tick();
    check("t4_draining", {flushing, 8'(n_complete - n0)}, {1'b1, 8'd0});
    done_req = 1;
    repeat (5) tick();
    check("t4_still_draining", n_complete - n0, 0);
    done_req = 1;
    wait_done("t4_done", 10);
    auto_done = 1;

    // mshrIdle low 10 cycles, then read grant withheld 3 cycles
    clear_model();
    mshrIdle = 0;
    grt_hold = 3;
    start_flush(t_ack);
    n0 = 0;
    repeat (10) begin
      tick();
      if (arrayReq || !flushing) n0++;
    end
    check("t5_wait_mshr", n0, 0);
    mshrIdle = 1;
    tick();
    check("t5_first_read", {arrayReq, arrayWE, arrayIndex, arrayWay}, 5'b10000);
    repeat (3) tick();
    check("t5_read_held", {arrayReq, arrayWE}, 2'b10);
    tick();
    check("t5_read_released", arrayReq, 0);
    wait_done("t5_done", 60);
    check("t5_arr_stable", arr_unstable, 0);

    // Reset during WB with one writeback outstanding
    clear_model();
    m_valid[0] = 1; m_dirty[0] = 1;
    m_valid[3] = 1; m_dirty[3] = 1; m_tag[3] = 20'h00ABC;
    auto_done = 0;
    start_flush(t_ack);
    for (int i = 0; i < 40 && n_ack < 1; i++) tick();
    ack_hold = 100;
    for (int i = 0; i < 40 && !memReq; i++) tick();
    check("t6_in_wb", memReq, 1);
    tick();
    rst = 0;
    #1;
    check("t6_reset_outputs", outs(), '0);
    repeat (2) tick();
    rst = 1;
    auto_done = 1;
    rd_log.delete(); wb_log.delete();
    tick();
    start_flush(t_ack);
    wait_done("t6_done", 80);
    if (rd_log.size() > 0) check("t6_restart_index", rd_log[0], 3'd0);
    check("t6_nwb", wb_log.size(), 1);
    if (wb_log.size() > 0) check("t6_memaddr", wb_log[0], 26'h2AF10);

    check("pulse_widths", pulse_err, 0);
    check("mem_stable", mem_unstable, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
